// File: rtl/ssram_pkg.sv
// Shared definitions for the parametrised SSRAM bus slave: FSM encoding and counter widths.
package ssram_pkg;

  localparam int unsigned BurstCntW         = 9;
  localparam int unsigned MaxReadWaitStates = 3;
  localparam int unsigned WaitCntW          = 2;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StWait,
    StRead,
    StEndTrans,
    StError
  } ssram_state_e;

endpackage

// File: rtl/ssram_if.sv
// Multiplexed address/data bus seen by one slave; master drives the *In side.
interface ssram_if;
  import ssram_pkg::*;

  logic                   beginTransactionIn;
  logic                   endTransactionIn;
  logic                   readNotWriteIn;
  logic                   dataValidIn;
  logic                   busyIn;
  logic                   busErrorIn;
  logic [31:0]            addressDataIn;
  logic [3:0]             byteEnablesIn;
  logic [BurstCntW-2:0]   burstSizeIn;
  logic                   endTransactionOut;
  logic                   dataValidOut;
  logic                   busErrorOut;
  logic [31:0]            addressDataOut;

  modport master (
    output beginTransactionIn, endTransactionIn, readNotWriteIn, dataValidIn, busyIn,
           busErrorIn, addressDataIn, byteEnablesIn, burstSizeIn,
    input  endTransactionOut, dataValidOut, busErrorOut, addressDataOut
  );

  modport slave (
    input  beginTransactionIn, endTransactionIn, readNotWriteIn, dataValidIn, busyIn,
           busErrorIn, addressDataIn, byteEnablesIn, burstSizeIn,
    output endTransactionOut, dataValidOut, busErrorOut, addressDataOut
  );
endinterface

// File: rtl/ssram_byte_lane.sv
// One byte lane of the SSRAM: synchronous write and registered synchronous read, no reset.
module ssram_byte_lane #(
  parameter int unsigned AddrW = 11
) (
  input  logic             clock,
  input  logic             i_we,
  input  logic             i_re,
  input  logic [AddrW-1:0] i_addr,
  input  logic [7:0]       i_wdata,
  output logic [7:0]       o_rdata
);
  localparam int unsigned Depth = 1 << AddrW;

  logic [7:0] r_mem [Depth];
  logic [7:0] r_rdata;

  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/ssram_param.sv
// Parametrised SSRAM bus slave: size, read wait states, ROM mode, wrapping bursts.
module ssram_param
  import ssram_pkg::*;
#(
  parameter logic [31:0] baseAddress    = 32'h5000_0000,
  parameter int unsigned sizeLog2       = 13,
  parameter int unsigned readWaitStates = 0,
  parameter bit          writeProtect   = 1'b0
) (
  input logic    clock,
  input logic    nReset,
  ssram_if.slave bus
);
  localparam int unsigned          AddrW    = sizeLog2 - 2;
  localparam logic [WaitCntW-1:0]  WaitLoad = WaitCntW'(readWaitStates);
  localparam bit                   HasWait  = (readWaitStates != 0);

  logic                 r_begin, r_end, r_rnw, r_dv_in, r_busy, r_berr;
  logic [31:0]          r_ad;
  logic [3:0]           r_be_in;
  logic [BurstCntW-2:0] r_burst;

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      r_begin <= 1'b0;
      r_end   <= 1'b0;
      r_rnw   <= 1'b0;
      r_dv_in <= 1'b0;
      r_busy  <= 1'b0;
      r_berr  <= 1'b0;
      r_ad    <= '0;
      r_be_in <= '0;
      r_burst <= '0;
    end else begin
      r_begin <= bus.beginTransactionIn;
      r_end   <= bus.endTransactionIn;
      r_rnw   <= bus.readNotWriteIn;
      r_dv_in <= bus.dataValidIn;
      r_busy  <= bus.busyIn;
      r_berr  <= bus.busErrorIn;
      r_ad    <= bus.addressDataIn;
      r_be_in <= bus.byteEnablesIn;
      r_burst <= bus.burstSizeIn;
    end
  end

  ssram_state_e         r_state, w_state_nxt;
  logic [AddrW-1:0]     r_ptr, w_ptr_nxt;
  logic [3:0]           r_be, w_be_nxt;
  logic [WaitCntW-1:0]  r_wcnt, w_wcnt_nxt;
  logic [BurstCntW-1:0] r_bcnt, w_bcnt_nxt;
  logic                 r_dv_out, w_dv_out_nxt;
  logic                 w_hit, w_we, w_re;
  logic [31:0]          w_rdata;

  assign w_hit = r_begin && ((r_ad >> sizeLog2) == (baseAddress >> sizeLog2));

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      r_state  <= StIdle;
      r_ptr    <= '0;
      r_be     <= '0;
      r_wcnt   <= '0;
      r_bcnt   <= '0;
      r_dv_out <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_be     <= w_be_nxt;
      r_wcnt   <= w_wcnt_nxt;
      r_bcnt   <= w_bcnt_nxt;
      r_dv_out <= w_dv_out_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_ptr;
    w_be_nxt     = r_be;
    w_wcnt_nxt   = r_wcnt;
    w_bcnt_nxt   = r_bcnt;
    w_dv_out_nxt = 1'b0;
    w_we         = 1'b0;
    w_re         = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_hit && !r_berr) begin
          w_ptr_nxt  = r_ad[sizeLog2-1:2];
          w_be_nxt   = r_be_in;
          w_bcnt_nxt = {1'b0, r_burst};
          w_wcnt_nxt = WaitLoad;
          if (!r_rnw)      w_state_nxt = writeProtect ? StError : StWrite;
          else if (HasWait) w_state_nxt = StWait;
          else              w_state_nxt = StRead;
        end
      end
      StWrite: begin
        if (r_berr) begin
          w_state_nxt = StIdle;
        end else begin
          if (r_dv_in) begin
            w_we      = 1'b1;
            w_ptr_nxt = r_ptr + AddrW'(1);
          end
          if (r_end) w_state_nxt = StIdle;
        end
      end
      StWait: begin
        // A stalled beat stays on the bus; the idle cycles start once it is taken.
        if (r_berr) begin
          w_state_nxt = StEndTrans;
        end else if (r_busy && r_dv_out) begin
          w_dv_out_nxt = 1'b1;
        end else begin
          w_wcnt_nxt = r_wcnt - WaitCntW'(1);
          if (r_wcnt == WaitCntW'(1)) w_state_nxt = StRead;
        end
      end
      StRead: begin
        if (r_berr) begin
          w_state_nxt = StEndTrans;
        end else if (r_busy) begin
          w_dv_out_nxt = r_dv_out;
        end else if (!r_bcnt[BurstCntW-1]) begin
          w_re         = 1'b1;
          w_dv_out_nxt = 1'b1;
          w_ptr_nxt    = r_ptr + AddrW'(1);
          w_bcnt_nxt   = r_bcnt - BurstCntW'(1);
          if (HasWait && (r_bcnt != '0)) begin
            w_state_nxt = StWait;
            w_wcnt_nxt  = WaitLoad;
          end
        end else begin
          w_state_nxt = StEndTrans;
        end
      end
      StEndTrans: w_state_nxt = StIdle;
      StError:    w_state_nxt = StIdle;
      default:    w_state_nxt = StIdle;
    endcase
  end

  for (genvar i = 0; i < 4; i++) begin : g_lane
    ssram_byte_lane #(
      .AddrW(AddrW)
    ) u_lane (
      .clock  (clock),
      .i_we   (w_we && r_be[i]),
      .i_re   (w_re),
      .i_addr (r_ptr),
      .i_wdata(r_ad[8*i +: 8]),
      .o_rdata(w_rdata[8*i +: 8])
    );
  end

  assign bus.dataValidOut      = r_dv_out;
  assign bus.addressDataOut    = r_dv_out ? w_rdata : '0;
  assign bus.endTransactionOut = (r_state == StEndTrans);
  assign bus.busErrorOut       = (r_state == StError);
endmodule

// File: tb/tb_ssram_param.sv
// Directed bench for ssram_param: three instances (no wait, two wait states, ROM) on one bus.
module tb_ssram_param;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        nReset;
  logic        t_begin, t_end, t_rnw, t_dv, t_busy, t_berr;
  logic [31:0] t_ad;
  logic [3:0]  t_be;
  logic [7:0]  t_burst;

  ssram_if b0 ();
  ssram_if b2 ();
  ssram_if br ();

  assign b0.beginTransactionIn = t_begin;
  assign b0.endTransactionIn   = t_end;
  assign b0.readNotWriteIn     = t_rnw;
  assign b0.dataValidIn        = t_dv;
  assign b0.busyIn             = t_busy;
  assign b0.busErrorIn         = t_berr;
  assign b0.addressDataIn      = t_ad;
  assign b0.byteEnablesIn      = t_be;
  assign b0.burstSizeIn        = t_burst;
  assign b2.beginTransactionIn = t_begin;
  assign b2.endTransactionIn   = t_end;
  assign b2.readNotWriteIn     = t_rnw;
  assign b2.dataValidIn        = t_dv;
  assign b2.busyIn             = t_busy;
  assign b2.busErrorIn         = t_berr;
  assign b2.addressDataIn      = t_ad;
  assign b2.byteEnablesIn      = t_be;
  assign b2.burstSizeIn        = t_burst;
  assign br.beginTransactionIn = t_begin;
  assign br.endTransactionIn   = t_end;
  assign br.readNotWriteIn     = t_rnw;
  assign br.dataValidIn        = t_dv;
  assign br.busyIn             = t_busy;
  assign br.busErrorIn         = t_berr;
  assign br.addressDataIn      = t_ad;
  assign br.byteEnablesIn      = t_be;
  assign br.burstSizeIn        = t_burst;

  ssram_param #(
    .baseAddress(32'h5000_0000), .sizeLog2(13), .readWaitStates(0), .writeProtect(1'b0)
  ) u_dut0 (
    .clock (clock),
    .nReset(nReset),
    .bus   (b0)
  );

  ssram_param #(
    .baseAddress(32'h6000_0000), .sizeLog2(13), .readWaitStates(2), .writeProtect(1'b0)
  ) u_dut2 (
    .clock (clock),
    .nReset(nReset),
    .bus   (b2)
  );

  ssram_param #(
    .baseAddress(32'h7000_0000), .sizeLog2(13), .readWaitStates(0), .writeProtect(1'b1)
  ) u_rom (
    .clock (clock),
    .nReset(nReset),
    .bus   (br)
  );

  int          n_cmp = 0;
  int          n_fail = 0;
  int          sel;
  logic        s_dv, s_end, s_berr;
  logic [31:0] s_ad;
  int          nbeats, end_n, end_cyc, berr_n, berr_cyc;
  logic [31:0] bd [32];
  int          bc [32];
  logic        cap_dv [32];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    case (sel)
      0: begin
        s_dv = b0.dataValidOut; s_end = b0.endTransactionOut;
        s_berr = b0.busErrorOut; s_ad = b0.addressDataOut;
      end
      1: begin
        s_dv = br.dataValidOut; s_end = br.endTransactionOut;
        s_berr = br.busErrorOut; s_ad = br.addressDataOut;
      end
      default: begin
        s_dv = b2.dataValidOut; s_end = b2.endTransactionOut;
        s_berr = b2.busErrorOut; s_ad = b2.addressDataOut;
      end
    endcase
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    sample();
  endtask

  task automatic clear_bus();
    t_begin = 0; t_end = 0; t_rnw = 0; t_dv = 0; t_busy = 0; t_berr = 0;
    t_ad = '0; t_be = '0; t_burst = '0;
  endtask

  task automatic note_berr(input int c);
    if (s_berr) begin
      berr_n++;
      if (berr_cyc < 0) berr_cyc = c;
    end
  endtask

  task automatic bus_begin(input logic [31:0] addr, input logic rnw, input logic [3:0] be,
                           input logic [7:0] burst);
    t_begin = 1; t_ad = addr; t_rnw = rnw; t_be = be; t_burst = burst;
    tick();
    t_begin = 0; t_ad = '0; t_rnw = 0; t_be = '0; t_burst = '0;
  endtask

  // Burst write of n beats with data d0, d0+1, ...
  task automatic write_txn(input int s, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] d0, input int n);
    sel = s; berr_n = 0; berr_cyc = -1;
    bus_begin(addr, 1'b0, be, 8'(n - 1));
    note_berr(0);
    for (int i = 0; i < n; i++) begin
      t_dv = 1; t_ad = d0 + 32'(i);
      tick();
      note_berr(i + 1);
    end
    t_dv = 0; t_ad = '0; t_end = 1;
    tick();
    note_berr(n + 1);
    t_end = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      note_berr(n + 2 + i);
    end
  endtask

  // Read burst, capturing every cycle; busy is high for iterations [bf, bf+bl).
  task automatic read_run(input int s, input logic [31:0] addr, input logic [7:0] burst,
                          input int ncyc, input int bf, input int bl);
    sel = s; nbeats = 0; end_n = 0; end_cyc = -1;
    bus_begin(addr, 1'b1, 4'hF, burst);
    for (int c = 0; c < ncyc; c++) begin
      t_busy = (c >= bf) && (c < bf + bl);
      tick();
      cap_dv[c] = s_dv;
      if (s_dv && nbeats < 32) begin
        bd[nbeats] = s_ad;
        bc[nbeats] = c;
        nbeats++;
      end
      if (s_end) begin
        end_n++;
        if (end_cyc < 0) end_cyc = c;
      end
    end
    t_busy = 0;
  endtask

  logic [17:0] exp_dv;
  logic [31:0] exp_stall [7];
  logic [31:0] exp_wrap [3];

  initial begin
    clear_bus();
    nReset = 0;
    u_rom.g_lane[0].u_lane.r_mem[0] = 8'h0D;
    u_rom.g_lane[1].u_lane.r_mem[0] = 8'hF0;
    u_rom.g_lane[2].u_lane.r_mem[0] = 8'hFE;
    u_rom.g_lane[3].u_lane.r_mem[0] = 8'hCA;

    tick();
    for (int s = 0; s < 3; s++) begin
      sel = s;
      sample();
      check_eq("rst_dv", 32'(s_dv), 0);
      check_eq("rst_end", 32'(s_end), 0);
      check_eq("rst_berr", 32'(s_berr), 0);
      check_eq("rst_ad", s_ad, 0);
    end
    @(negedge clock);
    nReset = 1;
    tick();
    tick();

    // Single write then single read
    write_txn(0, 32'h5000_0010, 4'hF, 32'hDEAD_BEEF, 1);
    check_eq("wr_berr", berr_n, 0);
    read_run(0, 32'h5000_0010, 8'd0, 8, -1, 0);
    check_eq("rd1_beats", nbeats, 1);
    check_eq("rd1_data", bd[0], 32'hDEAD_BEEF);
    check_eq("rd1_beat_cyc", bc[0], 1);
    check_eq("rd1_end_n", end_n, 1);
    check_eq("rd1_end_cyc", end_cyc, 2);

    // Partial byte-lane write
    write_txn(0, 32'h5000_0010, 4'b0101, 32'h1122_3344, 1);
    read_run(0, 32'h5000_0010, 8'd0, 8, -1, 0);
    check_eq("part_beats", nbeats, 1);
    check_eq("part_data", bd[0], 32'hDE22_BE44);

    // Two wait states, 4 beats, beat 2 stalled for three cycles
    write_txn(2, 32'h6000_0000, 4'hF, 32'd0, 4);
    read_run(2, 32'h6000_0000, 8'd3, 18, 9, 3);
    exp_dv = 18'b001001111001001000;
    exp_stall = '{32'd0, 32'd1, 32'd2, 32'd2, 32'd2, 32'd2, 32'd3};
    for (int c = 0; c < 18; c++) check_eq($sformatf("ws_dv_c%0d", c), 32'(cap_dv[c]), 32'(exp_dv[c]));
    check_eq("ws_beats", nbeats, 7);
    for (int i = 0; i < 7; i++) check_eq($sformatf("ws_data%0d", i), bd[i], exp_stall[i]);
    check_eq("ws_end_n", end_n, 1);
    check_eq("ws_end_cyc", end_cyc, 16);

    // Wrap-around at the top of the window
    write_txn(0, 32'h5000_1FFC, 4'hF, 32'hC0DE_07FF, 1);
    write_txn(0, 32'h5000_0000, 4'hF, 32'hC0DE_0000, 1);
    write_txn(0, 32'h5000_0004, 4'hF, 32'hC0DE_0001, 1);
    read_run(0, 32'h5000_1FFC, 8'd2, 8, -1, 0);
    exp_wrap = '{32'hC0DE_07FF, 32'hC0DE_0000, 32'hC0DE_0001};
    check_eq("wrap_beats", nbeats, 3);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("wrap_data%0d", i), bd[i], exp_wrap[i]);
      check_eq($sformatf("wrap_cyc%0d", i), bc[i], i + 1);
    end
    check_eq("wrap_end_cyc", end_cyc, 4);

    // ROM mode
    write_txn(1, 32'h7000_0000, 4'hF, 32'h1234_5678, 1);
    check_eq("rom_berr_n", berr_n, 1);
    check_eq("rom_berr_cyc", berr_cyc, 1);
    read_run(1, 32'h7000_0000, 8'd0, 6, -1, 0);
    check_eq("rom_beats", nbeats, 1);
    check_eq("rom_data", bd[0], 32'hCAFE_F00D);

    // Out-of-window access must not respond or alias
    write_txn(0, 32'h5000_2000, 4'hF, 32'hBAD0_BAD0, 1);
    check_eq("dec_wr_berr", berr_n, 0);
    read_run(0, 32'h5000_2000, 8'd0, 8, -1, 0);
    check_eq("dec_beats", nbeats, 0);
    check_eq("dec_end_n", end_n, 0);
    read_run(0, 32'h5000_0000, 8'd0, 6, -1, 0);
    check_eq("dec_alias", bd[0], 32'hC0DE_0000);

    // Reset in the middle of a burst
    sel = 0;
    bus_begin(32'h5000_0000, 1'b1, 4'hF, 8'd7);
    tick();
    tick();
    tick();
    check_eq("mid_dv", 32'(s_dv), 1);
    check_eq("mid_data", s_ad, 32'hC0DE_0001);
    #1;
    nReset = 0;
    #1;
    sample();
    check_eq("arst_dv", 32'(s_dv), 0);
    check_eq("arst_end", 32'(s_end), 0);
    check_eq("arst_ad", s_ad, 0);
    @(posedge clock);
    @(negedge clock);
    nReset = 1;
    end_n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (s_end || s_dv) end_n++;
    end
    check_eq("post_rst_quiet", end_n, 0);
    read_run(0, 32'h5000_0010, 8'd0, 6, -1, 0);
    check_eq("post_rst_beats", nbeats, 1);
    check_eq("post_rst_data", bd[0], 32'hDE22_BE44);
    check_eq("post_rst_end", end_n, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
